// File: rtl/clct_zone_busy_sched.sv
// Per-CFEB dead-time scheduler feeding the busy lines of the best-1-of-7 sorter.
// Accepted CLCTs mask their zone (and optionally edge neighbours) for dead_time clocks.
module clct_zone_busy_sched #(
    parameter int MXCFEB  = 7,
    parameter int MXKEYBX = 8,
    parameter int MXDEADB = 4,
    parameter int EDGE_HS = 2,
    parameter int MXCNTB  = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [MXDEADB-1:0] dead_time,
    input  logic               spread_en,
    input  logic               purge,
    input  logic               clct_vld,
    input  logic [MXKEYBX-1:0] clct_key,
    output logic [MXCFEB-1:0]  bsy,
    output logic               any_bsy,
    output logic               bad_key,
    output logic [MXCNTB-1:0]  accept_cnt,
    output logic [MXCNTB-1:0]  drop_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PURGE = 2'd2
    } state_t;

    localparam logic [4:0] EDGE_LO = 5'(EDGE_HS);
    localparam logic [4:0] EDGE_HI = 5'(32 - EDGE_HS);

    state_t state;
    state_t state_nxt;

    logic [MXCFEB-1:0][MXDEADB-1:0] timer;
    logic [MXCFEB-1:0][MXDEADB-1:0] timer_nxt;
    logic [MXCFEB-1:0][MXDEADB-1:0] timer_dec;
    logic [MXCFEB-1:0]              bsy_nxt;

    logic [2:0] zone;
    logic [4:0] ofs;
    logic       key_bad;
    logic       strobe;
    logic       hit_busy;
    logic       accept;
    logic       drop;
    logic       own;
    logic       nbr;

    assign zone    = clct_key[MXKEYBX-1:5];
    assign ofs     = clct_key[4:0];
    assign key_bad = (zone >= 3'(MXCFEB));
    assign strobe  = (state == RUN) && clct_vld;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (enable) state_nxt = RUN;
            RUN: begin
                if (!enable)    state_nxt = IDLE;
                else if (purge) state_nxt = PURGE;
            end
            PURGE:   state_nxt = enable ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        hit_busy = 1'b0;
        for (int i = 0; i < MXCFEB; i++) begin
            if (zone == 3'(i) && timer[i] != '0) hit_busy = 1'b1;
        end
    end

    assign accept = strobe && !key_bad && !hit_busy;
    assign drop   = strobe && !key_bad && hit_busy;

    // Neighbour loads take the longer of the running and new dead time.
    always_comb begin
        own = 1'b0;
        nbr = 1'b0;
        for (int i = 0; i < MXCFEB; i++) begin
            timer_dec[i] = (timer[i] != '0) ? timer[i] - 1'b1 : '0;
            timer_nxt[i] = timer_dec[i];
            own = accept && (zone == 3'(i));
            nbr = accept && spread_en &&
                  (((ofs < EDGE_LO) && (zone == 3'(i + 1))) ||
                   ((ofs >= EDGE_HI) && (zone + 3'd1 == 3'(i))));
            if (own) begin
                timer_nxt[i] = dead_time;
            end else if (nbr) begin
                timer_nxt[i] = (timer_dec[i] > dead_time) ? timer_dec[i]
                                                          : dead_time;
            end
            if (state != RUN || state_nxt != RUN) timer_nxt[i] = '0;
            bsy_nxt[i] = (timer_nxt[i] != '0);
        end
        if (state_nxt == PURGE) bsy_nxt = '1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timer   <= '0;
            bsy     <= '0;
            any_bsy <= 1'b0;
        end else begin
            timer   <= timer_nxt;
            bsy     <= bsy_nxt;
            any_bsy <= |bsy_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bad_key    <= 1'b0;
            accept_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (strobe && key_bad) bad_key <= 1'b1;
            if (accept && accept_cnt != '1) accept_cnt <= accept_cnt + 1'b1;
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_clct_zone_busy_sched.sv
// Directed bench for the zone busy scheduler: latency, spread, drop,
// bad key, purge/enable, reset and counter saturation.
module tb_clct_zone_busy_sched;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  dead_time;
    logic        spread_en;
    logic        purge;
    logic        clct_vld;
    logic [7:0]  clct_key;
    logic [6:0]  bsy;
    logic        any_bsy;
    logic        bad_key;
    logic [15:0] accept_cnt;
    logic [15:0] drop_cnt;

    int vectors = 0;
    int errors  = 0;

    clct_zone_busy_sched dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .dead_time  (dead_time),
        .spread_en  (spread_en),
        .purge      (purge),
        .clct_vld   (clct_vld),
        .clct_key   (clct_key),
        .bsy        (bsy),
        .any_bsy    (any_bsy),
        .bad_key    (bad_key),
        .accept_cnt (accept_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bsy(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, bsy}, {25'd0, exp});
        chk({tag, "_any"}, {31'd0, any_bsy}, {31'd0, |exp});
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; dead_time = 4'd0; spread_en = 1'b0;
        purge = 1'b0; clct_vld = 1'b0; clct_key = 8'd0;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk_bsy("rst_bsy", 7'h00);
        chk("rst_bad", {31'd0, bad_key}, 32'd0);
        chk("rst_acc", {16'd0, accept_cnt}, 32'd0);
        chk("rst_drop", {16'd0, drop_cnt}, 32'd0);

        // single accept, key 70 -> zone 2
        enable = 1'b1;
        tick();
        dead_time = 4'd3; clct_vld = 1'b1; clct_key = 8'd70;
        tick();
        clct_vld = 1'b0;
        chk_bsy("single_n1", 7'h04);
        chk("single_acc", {16'd0, accept_cnt}, 32'd1);
        tick(); chk_bsy("single_n2", 7'h04);
        tick(); chk_bsy("single_n3", 7'h04);
        tick(); chk_bsy("single_n4", 7'h00);

        // spread: key 96 (zone 3, ofs 0) then key 63 (zone 1, ofs 31)
        spread_en = 1'b1; dead_time = 4'd4; clct_vld = 1'b1; clct_key = 8'd96;
        tick(); clct_vld = 1'b0;
        chk_bsy("spread_c1", 7'h0C);
        tick(); chk_bsy("spread_c2", 7'h0C);
        clct_vld = 1'b1; clct_key = 8'd63;
        tick(); clct_vld = 1'b0;
        chk_bsy("spread_c3", 7'h0E);
        tick(); chk_bsy("spread_c4", 7'h0E);
        tick(); chk_bsy("spread_ext_c5", 7'h06);
        tick(); chk_bsy("spread_c6", 7'h06);
        tick(); chk_bsy("spread_c7", 7'h00);
        chk("spread_acc", {16'd0, accept_cnt}, 32'd3);

        // no spread: own zone only
        spread_en = 1'b0; clct_vld = 1'b1; clct_key = 8'd96;
        tick(); clct_vld = 1'b0;
        chk_bsy("nospread_c1", 7'h08);
        tick(); tick(); tick();
        chk_bsy("nospread_c4", 7'h08);
        tick(); chk_bsy("nospread_c5", 7'h00);

        // drop: key 40 then key 45, both zone 1
        dead_time = 4'd5; clct_vld = 1'b1; clct_key = 8'd40;
        tick(); chk_bsy("drop_n1", 7'h02);
        clct_key = 8'd45;
        tick(); clct_vld = 1'b0;
        chk("drop_cnt", {16'd0, drop_cnt}, 32'd1);
        chk("drop_acc", {16'd0, accept_cnt}, 32'd5);
        tick(); tick(); tick();
        chk_bsy("drop_n5", 7'h02);
        tick(); chk_bsy("drop_n6", 7'h00);

        // bad key
        dead_time = 4'd3; clct_vld = 1'b1; clct_key = 8'd230;
        tick(); clct_vld = 1'b0;
        chk("bad_set", {31'd0, bad_key}, 32'd1);
        chk_bsy("bad_bsy", 7'h00);
        chk("bad_acc", {16'd0, accept_cnt}, 32'd5);
        chk("bad_drop", {16'd0, drop_cnt}, 32'd1);
        tick(); chk("bad_sticky", {31'd0, bad_key}, 32'd1);

        // zero dead time
        dead_time = 4'd0; clct_vld = 1'b1; clct_key = 8'd10;
        tick(); clct_vld = 1'b0;
        chk("dt0_acc", {16'd0, accept_cnt}, 32'd6);
        chk_bsy("dt0_bsy", 7'h00);

        // purge
        dead_time = 4'd7; clct_vld = 1'b1; clct_key = 8'd10;
        tick(); clct_vld = 1'b0;
        chk_bsy("pre_purge", 7'h01);
        purge = 1'b1;
        tick(); purge = 1'b0;
        chk_bsy("purge_all", 7'h7F);
        clct_vld = 1'b1; clct_key = 8'd100;
        tick(); clct_vld = 1'b0;
        chk_bsy("post_purge", 7'h00);
        chk("purge_acc", {16'd0, accept_cnt}, 32'd7);

        // enable low wins over purge
        clct_vld = 1'b1; clct_key = 8'd10;
        tick(); clct_vld = 1'b0;
        chk_bsy("pre_dis", 7'h01);
        chk("pre_dis_acc", {16'd0, accept_cnt}, 32'd8);
        enable = 1'b0; purge = 1'b1;
        tick(); purge = 1'b0;
        chk_bsy("dis_idle", 7'h00);
        enable = 1'b1; clct_vld = 1'b1; clct_key = 8'd10;
        tick(); clct_vld = 1'b0;
        chk_bsy("idle_ignore_bsy", 7'h00);
        chk("idle_ignore_acc", {16'd0, accept_cnt}, 32'd8);

        // reset while all busy
        purge = 1'b1;
        tick(); purge = 1'b0;
        chk_bsy("rst_pre", 7'h7F);
        reset = 1'b1;
        tick(); reset = 1'b0;
        chk_bsy("rst_mid", 7'h00);
        chk("rst_mid_bad", {31'd0, bad_key}, 32'd0);
        chk("rst_mid_acc", {16'd0, accept_cnt}, 32'd0);
        chk("rst_mid_drop", {16'd0, drop_cnt}, 32'd0);

        // saturation
        tick();
        dead_time = 4'd0; clct_vld = 1'b1; clct_key = 8'd10;
        repeat (65536) tick();
        chk("sat_acc", {16'd0, accept_cnt}, 32'h0000FFFF);
        tick(); tick(); tick();
        clct_vld = 1'b0;
        chk("sat_hold", {16'd0, accept_cnt}, 32'h0000FFFF);
        chk_bsy("sat_bsy", 7'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
